// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the integer ALU.
//   ALU_WIDTH - default datapath width
//   OP_*      - 3-bit opcode encodings; 110/111 are reserved and act as NOP
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_MOD = 3'b101;
endpackage

// File: rtl/alu_divider.sv
// alu_divider: combinational unsigned restoring divider.
//   a   in  WIDTH  dividend
//   b   in  WIDTH  divisor
//   quo out WIDTH  floor(a/b), all ones when b==0
//   rem out WIDTH  a mod b, equals a when b==0
import alu_pkg::*;

module alu_divider #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  // rem_s[k] is the partial remainder after bit k of the dividend has been
  // brought down; rem_s[WIDTH] is the empty starting remainder.
  logic [WIDTH:0][WIDTH-1:0] rem_s;
  logic [WIDTH-1:0]          q_raw;
  logic                      b_zero;

  assign rem_s[WIDTH] = '0;
  assign b_zero       = (b == '0);

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    localparam int I = WIDTH - 1 - k;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign shifted = {rem_s[I+1], a[I]};
    assign diff    = shifted - {1'b0, b};
    // Partial remainder is always < b, so a borrow out of the W+1 bit
    // subtract means shifted < b and the trial is restored.
    assign q_raw[I] = ~diff[WIDTH];
    assign rem_s[I] = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  // Borrow detection above is only valid for b != 0, so the divide-by-zero
  // results are forced explicitly.
  assign quo = b_zero ? '1 : q_raw;
  assign rem = b_zero ? a  : rem_s[0];
endmodule

// File: rtl/alu.sv
// alu: 32-bit unsigned integer ALU with registered result and zero flag.
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset
//   A_bus in  WIDTH  operand A (dividend / minuend)
//   B_bus in  WIDTH  operand B (divisor / subtrahend)
//   op    in  3      operation select
//   C_bus out WIDTH  registered result
//   Z     out 1      registered zero flag (C_bus == 0)
// NOP and reserved opcodes hold both C_bus and Z.
import alu_pkg::*;

module alu #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] C_bus,
  output logic             Z
);
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res;
  logic             upd;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .a   (A_bus),
    .b   (B_bus),
    .quo (quo),
    .rem (rem)
  );

  always_comb begin
    res = '0;
    upd = 1'b1;
    case (op)
      OP_ADD:  res = A_bus + B_bus;
      OP_SUB:  res = A_bus - B_bus;
      OP_MUL:  res = A_bus * B_bus;  // low WIDTH bits of the product
      OP_DIV:  res = quo;
      OP_MOD:  res = rem;
      default: upd = 1'b0;           // NOP and reserved: hold
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C_bus <= '0;
      Z     <= 1'b0;
    end else if (upd) begin
      C_bus <= res;
      Z     <= (res == '0);
    end
  end
endmodule

// File: tb/tb_alu.sv
module tb_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] c;
  logic         z;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what C_bus/Z should hold.
  logic [W-1:0] mdl_c;
  logic         mdl_z;

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A_bus (a),
    .B_bus (b),
    .op    (op),
    .C_bus (c),
    .Z     (z)
  );

  always #5 clk = clk_en ? ~clk : clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] c;
    logic         z;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one operation, clock it, sample 1 time unit after the edge.
  task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
    a  = ia;
    b  = ib;
    op = iop;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: plain modulo-2^32 arithmetic in 64 bits.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
    longint unsigned ua, ub, r;
    bit hit;
    ua  = 64'(ia);
    ub  = 64'(ib);
    hit = 1'b1;
    r   = 0;
    case (iop)
      3'd1: r = ua + ub;
      3'd2: r = ua + 64'h1_0000_0000 - ub;
      3'd3: r = ua * ub;
      3'd4: r = (ub == 0) ? 64'hFFFF_FFFF : ua / ub;
      3'd5: r = (ub == 0) ? ua : ua % ub;
      default: hit = 1'b0;
    endcase
    if (hit) begin
      mdl_c = r[W-1:0];
      mdl_z = (r[W-1:0] == 0);
    end
  endtask

  initial begin
    vecs[0]  = '{32'd0,        32'd0, 3'b000, 32'd0,        1'b0};
    vecs[1]  = '{32'd10,       32'd6, 3'b001, 32'd16,       1'b0};
    vecs[2]  = '{32'd8,        32'd7, 3'b011, 32'd56,       1'b0};
    vecs[3]  = '{32'd8,        32'd7, 3'b010, 32'd1,        1'b0};
    vecs[4]  = '{32'd7,        32'd7, 3'b010, 32'd0,        1'b1};
    vecs[5]  = '{32'd6,        32'd7, 3'b010, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{32'd17,       32'd5, 3'b100, 32'd3,        1'b0};
    vecs[7]  = '{32'd17,       32'd5, 3'b101, 32'd2,        1'b0};
    vecs[8]  = '{32'd15,       32'd5, 3'b101, 32'd0,        1'b1};
    vecs[9]  = '{32'd17,       32'd0, 3'b100, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{32'd17,       32'd0, 3'b101, 32'd17,       1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 32'd1, 3'b001, 32'd0,        1'b1};
    vecs[12] = '{32'd123,      32'd456, 3'b000, 32'd0,      1'b1};
    vecs[13] = '{32'd99,       32'd3, 3'b111, 32'd0,        1'b1};
    vecs[14] = '{32'd5,        32'd5, 3'b110, 32'd0,        1'b1};

    // Async reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    chk("rst_c", c, '0);
    chk("rst_z", {31'd0, z}, {31'd0, 1'b0});
    #2 rst = 1'b0;
    clk_en = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("vec%0d_c", i), c, vecs[i].c);
      chk($sformatf("vec%0d_z", i), {31'd0, z}, {31'd0, vecs[i].z});
    end

    // Reset mid-stream, pulsed between edges.
    step(32'd8, 32'd7, 3'b011);
    chk("pre_rst_c", c, 32'd56);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_c", c, '0);
    chk("mid_rst_z", {31'd0, z}, {31'd0, 1'b0});
    #1 rst = 1'b0;
    step(32'd10, 32'd6, 3'b001);
    chk("post_rst_c", c, 32'd16);
    chk("post_rst_z", {31'd0, z}, {31'd0, 1'b0});

    // Randomized run against the model.
    mdl_c = c;
    mdl_z = z;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: ra = W'($urandom_range(0, 100));
        3: rb = ra;
        default: ;
      endcase
      model(ra, rb, rop);
      step(ra, rb, rop);
      chk($sformatf("rnd%0d_c op%0d", i, rop), c, mdl_c);
      chk($sformatf("rnd%0d_z op%0d", i, rop), {31'd0, z}, {31'd0, mdl_z});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for each processor core, operating on unsigned operands.
- Takes two operand buses and a 3-bit opcode, and produces a result bus plus a zero flag.
- Outputs are registered: one clock of latency between operands/opcode and result.
- Sits between the core's register-file buses (A/B) and the write-back bus (C). The control unit samples Z for conditional branches.

Parameters:
- WIDTH, 32, datapath width of A_bus, B_bus and C_bus.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- A_bus  in  WIDTH  operand A (dividend / minuend)
- B_bus  in  WIDTH  operand B (divisor / subtrahend)
- op  in  3  operation select
- C_bus  out  WIDTH  registered result
- Z  out  1  registered zero flag
- Instantiation is by named connection.

Behaviour:
- Reset: while rst=1 (asynchronously, no clock needed), C_bus=0 and Z=0. Release is synchronous to the next rising clk.
- Each rising clk with rst=0: compute result R from the current A_bus, B_bus and op. Register C_bus<=R and Z<=(R==0).
- Latency is exactly 1 cycle; throughput is one operation per cycle; no handshake.
- Opcodes, all unsigned and modulo 2^WIDTH:
  - 000 NOP: C_bus and Z hold their previous values.
  - 001 ADD: R=A+B; carry out discarded.
  - 010 SUB: R=A-B; two's-complement wrap, so 6-7 gives 32'hFFFF_FFFF and Z=0.
  - 011 MUL: R=low WIDTH bits of A*B.
  - 100 DIV: R=floor(A/B).
  - 101 MOD: R=A mod B.
  - 110, 111: reserved; behave as NOP (hold).
- Divide by zero (op 100 or 101 with B=0): DIV gives R=all ones (32'hFFFF_FFFF); MOD gives R=A. Z follows R. No exception or stall.
- Z is updated only when C_bus is updated; on NOP/reserved it holds.
- Reset asserted mid-operation wins immediately. Any in-flight result is discarded.
- No internal state other than the output registers.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_NOP=3'b000, OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b011, OP_DIV=3'b100, OP_MOD=3'b101;
  - the WIDTH default.
- One natural sub-module: alu_divider. It is a combinational unsigned restoring divider producing both quotient and remainder, including the divide-by-zero rules. The top-level alu contains the opcode decode mux, add/sub/mul, the zero detect and the output registers.

Test Plan:
- Reset: assert rst with no clock -> C_bus=0, Z=0 immediately. Deassert, then clock a NOP -> outputs stay 0/0.
- ADD and MUL: A=10, B=6, op=001, one clk -> C_bus=16, Z=0. Then A=8, B=7, op=011 -> C_bus=56, Z=0.
- SUB:
  - A=8, B=7, op=010 -> C_bus=1, Z=0.
  - A=7, B=7 -> C_bus=0, Z=1.
  - A=6, B=7 -> C_bus=32'hFFFF_FFFF, Z=0.
- DIV/MOD:
  - A=17, B=5, op=100 -> C_bus=3, Z=0; op=101 -> C_bus=2, Z=0.
  - A=15, B=5, op=101 -> C_bus=0, Z=1.
  - A=17, B=0: op=100 -> 32'hFFFF_FFFF; op=101 -> 17.
- Hold and wrap: after ADD with A=32'hFFFF_FFFF, B=1 -> C_bus=0, Z=1. Then op=000 and op=111 with changing operands -> C_bus=0, Z=1 held.
- Async reset mid-stream: rst pulsed between clock edges while C_bus=56 -> C_bus=0, Z=0 before the next edge. The first post-reset clk with A=10, B=6, op=001 -> C_bus=16.
